pong_ball: RTL
==============

Name: pong_ball

Overview:
- Ball motion and draw stage for the Pong screen; the neighbour of the bar draw block.
- Consumes each bar's current y position, the same value the bar block exports as its current-position output.
- Moves an 8x8 ball across the 640x480 active area, bounces it off the walls and bars, and detects scoring.
- Drives a 1-bit `color` draw flag into the same pixel mixer the bar blocks feed.

Parameters:
- X_INIT, 316, ball serve x (left edge)
- Y_INIT, 236, ball serve y (top edge)
- BALL_SZ, 8, ball side in pixels
- STEP_DELAY, 20'hFFFFF, clk_in cycles between one-pixel steps
- BAR_L_X, 10, left bar x (left edge)
- BAR_R_X, 620, right bar x (left edge)
- BAR_W, 10, bar width
- BAR_H, 90, bar height
- Y_MIN, 6, top wall (first playable row)
- Y_MAX, 472, bottom wall (last playable row)
- X_MAX, 639, last column

Ports:
- clk_in  in  1  base clock from board
- i_rst  in  1  synchronous active-low reset
- enablePong  in  1  game enable; low freezes all state and blanks color
- serve  in  1  one-cycle pulse; launches ball from IDLE/SCORED
- o_active  in  1  high while a visible pixel is drawn
- o_x  in  10  current pixel x
- o_y  in  9  current pixel y
- bar_l_y  in  9  left bar top y
- bar_r_y  in  9  right bar top y
- ball_x  out  10  ball left edge
- ball_y  out  9  ball top edge
- score_l  out  4  left player points
- score_r  out  4  right player points
- point  out  1  one-cycle pulse on a score
- color  out  1  1 = ball pixel at (o_x,o_y)

Behaviour:
- Reset (i_rst low at a clk_in edge): state=IDLE, ball_x=X_INIT, ball_y=Y_INIT, dx=+1 (right), dy=+1 (down), delay=0, scores=0, point=0, color=0. Reset wins over every other input.
- enablePong low: all registers hold; color forced to 0 next cycle.
- States:
  - IDLE: ball parked at serve point. On serve: go to MOVE, delay cleared.
  - MOVE: delay counts up each cycle. At delay==STEP_DELAY it is a pending step. The step executes on the first cycle with color==0 (no update mid-ball-draw); then delay=0. Counter holds at STEP_DELAY while pending.
  - SCORED: ball reset to X_INIT/Y_INIT. dx points toward the player who conceded. dy unchanged. Waits for serve, then goes to MOVE.
- Step, evaluated on current position, in priority order:
  1. Left goal: dx=-1 and ball_x==0 -> score_r+1, point=1 for one cycle, go to SCORED.
  2. Right goal: dx=+1 and ball_x+BALL_SZ-1==X_MAX -> score_l+1, point pulse, go to SCORED.
  3. Left bar hit: dx=-1, ball_x==BAR_L_X+BAR_W+1, and y overlap (ball_y+BALL_SZ-1 >= bar_l_y and ball_y <= bar_l_y+BAR_H) -> dx=+1.
  4. Right bar hit: dx=+1, ball_x+BALL_SZ==BAR_R_X, and y overlap with bar_r_y -> dx=-1.
  5. Wall: dy=-1 and ball_y<=Y_MIN -> dy=+1; dy=+1 and ball_y+BALL_SZ-1>=Y_MAX -> dy=-1. Checked independently of x, so a corner reverses both axes in the same step.
  6. The position then moves one pixel along the updated dx and dy. Not applied for a goal.
- Bar y inputs are sampled at the step cycle only.
- Arithmetic: compares use 11-bit zero-extended sums, so no wrap.
- Scores saturate at 15; point still pulses.
- serve while in MOVE is ignored.
- color is registered one cycle after its inputs: color = o_active & enablePong & (ball_x <= o_x <= ball_x+BALL_SZ-1) & (ball_y <= o_y <= ball_y+BALL_SZ-1).
- Outside the active area color=0; no latch.
- Reset mid-move: next cycle is IDLE at the serve point with scores cleared.

Optional Feature:
- Macro: PONG_BALL_SPEEDUP_EN.
- Defined: a 20-bit step_limit register replaces the constant STEP_DELAY.
  - Resets to STEP_DELAY.
  - Each bar hit: step_limit -= step_limit>>4, floor 20'h10000.
  - Restored to STEP_DELAY on entering SCORED.
- Not defined: step period is always STEP_DELAY; no extra register.

Test Plan (STEP_DELAY=4 for sim):
- Reset then serve: ball at (316,236) -> after 5 cycles with color=0, ball at (317,237), dx=+1, dy=+1.
- Bottom wall: ball_y=464 (464+7=471), dy=+1, next step -> ball_y 465 (last row 472) -> next step reverses -> dy=-1, ball_y 464.
- Left bar hit: bar_l_y=200, ball_x=21, ball_y=250, dx=-1 -> dx=+1, ball_x=22. Same with bar_l_y=300 -> no bounce, ball_x=20.
- Left goal: ball_x=0, dx=-1 -> score_r 0->1, one-cycle point, state SCORED, ball at (316,236), dx=-1. Serve -> MOVE.
- Draw/hold: pending step with color=1 (o_x,o_y inside ball, o_active=1) -> position frozen until color=0. enablePong low -> color 0 next cycle, counters hold.
- Reset mid-MOVE with score_l=3 -> next cycle IDLE, scores 0, ball (316,236).

Source files
------------

// File: rtl/pong_ball_if.sv
// rtl/pong_ball_if.sv - pixel scan bus between the video timing source and the ball draw stage
interface pong_ball_if;
    logic       o_active;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic       color;

    modport master (output o_active, output o_x, output o_y, input color);
    modport slave  (input o_active, input o_x, input o_y, output color);
endinterface

// File: rtl/pong_ball.sv
// rtl/pong_ball.sv - Pong ball motion, bounce, scoring and draw flag; PONG_BALL_SPEEDUP_EN shortens the step period on bar hits
module pong_ball #(
    parameter int          X_INIT     = 316,
    parameter int          Y_INIT     = 236,
    parameter int          BALL_SZ    = 8,
    parameter logic [19:0] STEP_DELAY = 20'hFFFFF,
    parameter int          BAR_L_X    = 10,
    parameter int          BAR_R_X    = 620,
    parameter int          BAR_W      = 10,
    parameter int          BAR_H      = 90,
    parameter int          Y_MIN      = 6,
    parameter int          Y_MAX      = 472,
    parameter int          X_MAX      = 639
) (
    input  logic        clk_in,
    input  logic        i_rst,
    input  logic        enablePong,
    input  logic        serve,
    pong_ball_if.slave  pix,
    input  logic [8:0]  bar_l_y,
    input  logic [8:0]  bar_r_y,
    output logic [9:0]  ball_x,
    output logic [8:0]  ball_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        point
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SCORED = 2'd2
    } state_t;

    state_t      state_q;
    logic [9:0]  ball_x_q;
    logic [8:0]  ball_y_q;
    logic        dx_q;
    logic        dy_q;
    logic [19:0] delay_q;
    logic [3:0]  score_l_q;
    logic [3:0]  score_r_q;
    logic        point_q;
    logic        color_q;
    logic [19:0] step_limit;

`ifdef PONG_BALL_SPEEDUP_EN
    logic [19:0] step_limit_q;
    logic [19:0] limit_shrunk;
    logic [19:0] limit_d;

    assign step_limit   = step_limit_q;
    assign limit_shrunk = step_limit_q - (step_limit_q >> 4);
    assign limit_d      = (limit_shrunk < 20'h10000) ? 20'h10000 : limit_shrunk;
`else
    assign step_limit = STEP_DELAY;
`endif

    // All geometry compares are done at 11 bits so ball+size sums never wrap.
    logic [10:0] bx_lo, bx_hi, by_lo, by_hi;
    logic [10:0] bl_top, br_top;
    logic        goal_l, goal_r, hit_l, hit_r;
    logic        dx_d, dy_d;
    logic [9:0]  x_d;
    logic [8:0]  y_d;
    logic        pix_hit;
    logic        step_pending;

    always_comb begin
        bx_lo  = {1'b0, ball_x_q};
        bx_hi  = bx_lo + 11'(BALL_SZ - 1);
        by_lo  = {2'b00, ball_y_q};
        by_hi  = by_lo + 11'(BALL_SZ - 1);
        bl_top = {2'b00, bar_l_y};
        br_top = {2'b00, bar_r_y};

        goal_l = !dx_q && (ball_x_q == 10'd0);
        goal_r = dx_q && (bx_hi == 11'(X_MAX));
        hit_l  = !dx_q && (bx_lo == 11'(BAR_L_X + BAR_W + 1))
                 && (by_hi >= bl_top) && (by_lo <= bl_top + 11'(BAR_H));
        hit_r  = dx_q && (bx_lo + 11'(BALL_SZ) == 11'(BAR_R_X))
                 && (by_hi >= br_top) && (by_lo <= br_top + 11'(BAR_H));

        dx_d = dx_q;
        if (hit_l) begin
            dx_d = 1'b1;
        end else if (hit_r) begin
            dx_d = 1'b0;
        end

        // Walls are independent of x so a corner flips both directions at once.
        dy_d = dy_q;
        if (!dy_q && (by_lo <= 11'(Y_MIN))) begin
            dy_d = 1'b1;
        end else if (dy_q && (by_hi >= 11'(Y_MAX))) begin
            dy_d = 1'b0;
        end

        x_d = dx_d ? ball_x_q + 10'd1 : ball_x_q - 10'd1;
        y_d = dy_d ? ball_y_q + 9'd1  : ball_y_q - 9'd1;

        pix_hit = pix.o_active
                  && ({1'b0, pix.o_x} >= bx_lo) && ({1'b0, pix.o_x} <= bx_hi)
                  && ({2'b00, pix.o_y} >= by_lo) && ({2'b00, pix.o_y} <= by_hi);

        step_pending = (delay_q >= step_limit);
    end

    always_ff @(posedge clk_in) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            ball_x_q  <= 10'(X_INIT);
            ball_y_q  <= 9'(Y_INIT);
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            delay_q   <= 20'd0;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            point_q   <= 1'b0;
            color_q   <= 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
            step_limit_q <= STEP_DELAY;
`endif
        end else if (!enablePong) begin
            color_q <= 1'b0;
            point_q <= 1'b0;
        end else begin
            point_q <= 1'b0;
            color_q <= pix_hit;
            case (state_q)
                ST_IDLE, ST_SCORED: begin
                    if (serve) begin
                        state_q <= ST_MOVE;
                        delay_q <= 20'd0;
                    end
                end
                ST_MOVE: begin
                    if (!step_pending) begin
                        delay_q <= delay_q + 20'd1;
                    end else if (!color_q) begin
                        // Steps wait for the ball to be off the beam so it never tears mid-draw.
                        delay_q <= 20'd0;
                        if (goal_l || goal_r) begin
                            state_q  <= ST_SCORED;
                            ball_x_q <= 10'(X_INIT);
                            ball_y_q <= 9'(Y_INIT);
                            dx_q     <= goal_r;
                            point_q  <= 1'b1;
                            if (goal_l) begin
                                score_r_q <= (score_r_q == 4'd15) ? score_r_q : score_r_q + 4'd1;
                            end else begin
                                score_l_q <= (score_l_q == 4'd15) ? score_l_q : score_l_q + 4'd1;
                            end
`ifdef PONG_BALL_SPEEDUP_EN
                            step_limit_q <= STEP_DELAY;
`endif
                        end else begin
                            dx_q     <= dx_d;
                            dy_q     <= dy_d;
                            ball_x_q <= x_d;
                            ball_y_q <= y_d;
`ifdef PONG_BALL_SPEEDUP_EN
                            if (hit_l || hit_r) begin
                                step_limit_q <= limit_d;
                            end
`endif
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pix.color = color_q;
    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign point     = point_q;

endmodule
